// File: rtl/mux_4x1_16bit_if.sv
// Bus bundle for the registered 4-to-1 16-bit selector.
// The y_zero/y_neg flag signals exist only when MUX_4X1_16BIT_FLAGS_EN is defined.
interface mux_4x1_16bit_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 2;

  logic              en;
  logic [DATA_W-1:0] i0;
  logic [DATA_W-1:0] i1;
  logic [DATA_W-1:0] i2;
  logic [DATA_W-1:0] i3;
  logic [SEL_W-1:0]  select;
  logic [DATA_W-1:0] y;
  logic              y_valid;
`ifdef MUX_4X1_16BIT_FLAGS_EN
  logic              y_zero;
  logic              y_neg;

  modport master (output en, i0, i1, i2, i3, select,
                  input  y, y_valid, y_zero, y_neg);
  modport slave  (input  en, i0, i1, i2, i3, select,
                  output y, y_valid, y_zero, y_neg);
`else
  modport master (output en, i0, i1, i2, i3, select,
                  input  y, y_valid);
  modport slave  (input  en, i0, i1, i2, i3, select,
                  output y, y_valid);
`endif
endinterface

// File: rtl/mux_4x1_16bit.sv
// Registered 4-to-1 selector for 16-bit datapath words with capture enable.
// Optional zero/sign flags of the registered word via MUX_4X1_16BIT_FLAGS_EN.
module mux_4x1_16bit (
  input  logic            clk,
  input  logic            reset,
  mux_4x1_16bit_if.slave  bus
);
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] sel_word_c;

  // Full decode of the select lines; every code maps to exactly one input.
  always_comb begin
    sel_word_c = '0;
    case (bus.select)
      2'd0: sel_word_c = bus.i0;
      2'd1: sel_word_c = bus.i1;
      2'd2: sel_word_c = bus.i2;
      2'd3: sel_word_c = bus.i3;
    endcase
  end

  // Output register; hold when en is low, clear asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
    end else if (bus.en) begin
      bus.y       <= sel_word_c;
      bus.y_valid <= 1'b1;
    end
  end

`ifdef MUX_4X1_16BIT_FLAGS_EN
  // Flags are captured alongside y from the same word so they never disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.y_zero <= 1'b1;
      bus.y_neg  <= 1'b0;
    end else if (bus.en) begin
      bus.y_zero <= (sel_word_c == DATA_W'(0));
      bus.y_neg  <= sel_word_c[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_mux_4x1_16bit.sv
// Self-checking bench for mux_4x1_16bit: reference model of the selector plus
// directed vectors with literal expectations.
module tb_mux_4x1_16bit;
  logic clk;
  logic reset;

  mux_4x1_16bit_if bus ();

  mux_4x1_16bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks;
  int errors;
  bit running;

  logic [15:0] words [4];
  logic [15:0] exp_y;
  logic        exp_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: an enabled edge captures the word indexed by select.
  always @(posedge clk) begin
    if (!reset && bus.en) begin
      exp_y     = words[bus.select];
      exp_valid = 1'b1;
    end
  end

  // Compare DUT against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      check("model_y", bus.y, exp_y);
      check("model_valid", 16'(bus.y_valid), 16'(exp_valid));
`ifdef MUX_4X1_16BIT_FLAGS_EN
      check("model_zero", 16'(bus.y_zero), 16'(exp_y == 16'h0000));
      check("model_neg", 16'(bus.y_neg), 16'(exp_y[15]));
`endif
    end
  end

  task automatic step(input logic e, input logic [1:0] s);
    @(negedge clk);
    bus.en     = e;
    bus.select = s;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_y     = 16'h0000;
    exp_valid = 1'b0;
  endtask

  logic [15:0] sweep_exp [4];

  initial begin
    checks  = 0;
    errors  = 0;
    running = 1'b0;
    words[0] = 16'd25;
    words[1] = 16'd0;
    words[2] = 16'd32767;
    words[3] = 16'hFFFF;
    sweep_exp[0] = 16'd25;
    sweep_exp[1] = 16'd0;
    sweep_exp[2] = 16'd32767;
    sweep_exp[3] = 16'd65535;
    bus.i0 = words[0];
    bus.i1 = words[1];
    bus.i2 = words[2];
    bus.i3 = words[3];
    bus.en = 1'b0;
    bus.select = 2'd0;
    reset = 1'b1;
    model_reset();

    // Reset clears outputs without any clock edge
    #1;
    check("reset_y", bus.y, 16'h0000);
    check("reset_valid", 16'(bus.y_valid), 16'h0000);
`ifdef MUX_4X1_16BIT_FLAGS_EN
    check("reset_zero", 16'(bus.y_zero), 16'h0001);
    check("reset_neg", 16'(bus.y_neg), 16'h0000);
`endif
    running = 1'b1;

    @(negedge clk);
    reset = 1'b0;

    // Disabled edge after reset keeps outputs cleared
    step(1'b0, 2'd1);
    check("idle_y", bus.y, 16'h0000);
    check("idle_valid", 16'(bus.y_valid), 16'h0000);

    // Sweep all four selects
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 2'(s));
      check("sweep_y", bus.y, sweep_exp[s]);
      check("sweep_valid", 16'(bus.y_valid), 16'h0001);
    end

    // Hold with en low
    step(1'b1, 2'd2);
    check("hold_cap", bus.y, 16'd32767);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'd3);
      check("hold_y", bus.y, 16'd32767);
    end
    step(1'b1, 2'd3);
    check("hold_release", bus.y, 16'hFFFF);

`ifdef MUX_4X1_16BIT_FLAGS_EN
    step(1'b1, 2'd1);
    check("flag1_zero", 16'(bus.y_zero), 16'h0001);
    check("flag1_neg", 16'(bus.y_neg), 16'h0000);
    step(1'b1, 2'd3);
    check("flag3_zero", 16'(bus.y_zero), 16'h0000);
    check("flag3_neg", 16'(bus.y_neg), 16'h0001);
    step(1'b1, 2'd2);
    check("flag2_zero", 16'(bus.y_zero), 16'h0000);
    check("flag2_neg", 16'(bus.y_neg), 16'h0000);
`endif

    // Mid-stream reset between edges
    step(1'b1, 2'd0);
    step(1'b1, 2'd3);
    check("pre_rst_y", bus.y, 16'hFFFF);
    @(negedge clk);
    bus.select = 2'd2;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_y", bus.y, 16'h0000);
    check("midrst_valid", 16'(bus.y_valid), 16'h0000);
    @(posedge clk);
    #1;
    check("rst_held_y", bus.y, 16'h0000);
    #2;
    reset = 1'b0;
    step(1'b1, 2'd2);
    check("post_rst_y", bus.y, 16'd32767);
    check("post_rst_valid", 16'(bus.y_valid), 16'h0001);

    // Select glitching between edges; only the value at the edge counts
    @(negedge clk);
    bus.en = 1'b1;
    bus.select = 2'd0;
    #1 bus.select = 2'd3;
    #1 bus.select = 2'd1;
    @(posedge clk);
    #1;
    check("glitch_y", bus.y, 16'h0000);
    check("glitch_valid", 16'(bus.y_valid), 16'h0001);

    // Data changes between edges are only seen at the next enabled edge
    @(negedge clk);
    bus.en = 1'b0;
    bus.i1 = 16'h8001;
    words[1] = 16'h8001;
    @(posedge clk);
    #1;
    check("data_hold", bus.y, 16'h0000);
    step(1'b1, 2'd1);
    check("data_new", bus.y, 16'h8001);

    @(negedge clk);
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
